// File: rtl/spi_ram_ctrl.sv
// SPI-slave front end for the 256x8 RAM: deserialises 10-bit command frames,
// tracks read-address state and serialises RAM read data back on MISO.
module spi_ram_ctrl #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic [9:0]        rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO
);

  localparam int FRAME_W = 10;
  localparam int CNT_MAX = (DATA_W > FRAME_W) ? DATA_W : FRAME_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WAIT_W  = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX_WAIT,
    TX_SHIFT,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [9:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_done_q, rd_addr_done_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic                miso_q, miso_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = 1'b0;

    if (SS_n) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
        end
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          shift_d = {shift_q[7:0], MOSI};
          if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = (state_q == READ_DATA) ? TX_WAIT : HOLD;
            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        TX_WAIT: begin
          // The rx_valid cycle itself is not part of the wait window.
          if (!rx_valid_q) begin
            if (tx_valid) begin
              miso_d     = tx_data[DATA_W-1];
              tx_shift_d = tx_data << 1;
              bit_cnt_d  = CNT_W'(1);
              state_d    = TX_SHIFT;
            end else if (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1)) begin
              state_d = HOLD;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
        end
        TX_SHIFT: begin
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            rd_addr_done_d = 1'b0;
            bit_cnt_d      = '0;
            state_d        = HOLD;
          end else begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = tx_shift_q << 1;
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
        HOLD: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MISO     = miso_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: table of SPI frames with an rx_data scoreboard and
// per-cycle MISO expectations, plus hand-written async-reset sequence.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;

  int checks = 0;
  int errors = 0;
  logic [9:0] rx_q[$];
  logic [9:0] last_word = '0;

  typedef struct {
    logic       sel;
    logic [9:0] word;
    int         nbits;
    int         resp_cyc;   // negedge index at which the bench RAM raises tx_valid (0: never)
    logic [7:0] ram_byte;
    logic       exp_rx;
    logic       exp_shift;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl [0:13];

  spi_ram_ctrl #(.DATA_W(8), .TX_WAIT_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sel, input logic [9:0] word, input int nbits,
                              input int resp_cyc, input logic [7:0] ram_byte,
                              input logic exp_rx, input logic exp_shift,
                              input logic [7:0] exp_byte);
    vec_t v;
    v.sel = sel; v.word = word; v.nbits = nbits; v.resp_cyc = resp_cyc;
    v.ram_byte = ram_byte; v.exp_rx = exp_rx; v.exp_shift = exp_shift;
    v.exp_byte = exp_byte;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One negedge sample: MISO against expectation, rx_valid against scoreboard.
  task automatic tick(input logic em, input string tag);
    logic [9:0] e;
    @(negedge clk);
    chk(tag, 32'(MISO), 32'(em));
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%0h, none required (t=%0t)",
                 rx_data, $time);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e));
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic em;
    tick(1'b0, "miso_idle");
    SS_n = 1'b0; MOSI = 1'b0;
    tick(1'b0, "miso_chk");
    MOSI = v.sel;
    for (int i = 0; i < v.nbits; i++) begin
      tick(1'b0, "miso_rxbit");
      MOSI = v.word[9-i];
    end
    if (v.exp_rx) rx_q.push_back(v.word);
    if (v.nbits < 10) begin
      tick(1'b0, "miso_abort");
      SS_n = 1'b1; MOSI = 1'b0;
    end else begin
      for (int c = 12; c <= 26; c++) begin
        em = 1'b0;
        if (v.exp_shift && c >= v.resp_cyc + 1 && c <= v.resp_cyc + 8)
          em = v.exp_byte[v.resp_cyc + 8 - c];
        tick(em, "miso_resp");
        MOSI     = 1'($urandom_range(0, 1));
        tx_valid = (c == v.resp_cyc);
        tx_data  = (c == v.resp_cyc) ? v.ram_byte : 8'($urandom);
      end
      tick(1'b0, "miso_hold");
      SS_n = 1'b1; tx_valid = 1'b0; MOSI = 1'b0;
    end
    tick(1'b0, "miso_ss_hi");
    chk("rx_missing", 32'(rx_q.size()), 32'(0));
    if (v.nbits < 10) chk("rx_keep", 32'(rx_data), 32'(last_word));
    if (v.exp_rx) last_word = v.word;
  endtask

  initial begin
    logic [9:0] w;

    tbl[0]  = mk(1'b0, 10'h02A, 10, 13, 8'hFF, 1'b1, 1'b0, 8'h00); // write addr, stray tx_valid
    tbl[1]  = mk(1'b0, 10'h1C5, 10,  0, 8'h00, 1'b1, 1'b0, 8'h00); // write data
    tbl[2]  = mk(1'b1, 10'h22A, 10,  0, 8'h00, 1'b1, 1'b0, 8'h00); // READ_ADD
    tbl[3]  = mk(1'b1, 10'h3B6, 10, 13, 8'hC5, 1'b1, 1'b1, 8'hC5); // READ_DATA
    tbl[4]  = mk(1'b1, 10'h210, 10,  0, 8'h00, 1'b1, 1'b0, 8'h00); // READ_ADD
    tbl[5]  = mk(1'b1, 10'h300, 10, 17, 8'h81, 1'b1, 1'b0, 8'h00); // timeout, late tx_valid
    tbl[6]  = mk(1'b1, 10'h3FF, 10, 16, 8'h96, 1'b1, 1'b1, 8'h96); // still READ_DATA, last window cycle
    tbl[7]  = mk(1'b1, 10'h255, 10, 13, 8'h3C, 1'b1, 1'b0, 8'h00); // READ_ADD
    tbl[8]  = mk(1'b1, 10'h381, 10, 13, 8'h5A, 1'b1, 1'b1, 8'h5A); // READ_DATA
    tbl[9]  = mk(1'b1, 10'h201, 10, 13, 8'h77, 1'b1, 1'b0, 8'h00); // READ_ADD again
    tbl[10] = mk(1'b1, 10'h3F0,  4,  0, 8'h00, 1'b0, 1'b0, 8'h00); // aborted READ_DATA
    tbl[11] = mk(1'b1, 10'h3C3, 10, 13, 8'hE1, 1'b1, 1'b1, 8'hE1); // READ_DATA after abort
    tbl[12] = mk(1'b0, 10'h0FF,  6,  0, 8'h00, 1'b0, 1'b0, 8'h00); // aborted write
    tbl[13] = mk(1'b0, 10'h100, 10,  0, 8'h00, 1'b1, 1'b0, 8'h00); // write

    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(1'b0, "rst_miso");
    tick(1'b0, "rst_miso");
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    rst = 1'b0;
    tick(1'b0, "miso_idle");

    for (int k = 0; k <= 13; k++) run_frame(tbl[k]);

    // Async reset in the middle of shifting out 0xA5.
    run_frame(mk(1'b1, 10'h2F0, 10, 0, 8'h00, 1'b1, 1'b0, 8'h00));
    tick(1'b0, "miso_idle");
    SS_n = 1'b0; MOSI = 1'b0;
    tick(1'b0, "miso_chk");
    MOSI = 1'b1;
    w = 10'h3A5;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, "miso_rxbit");
      MOSI = w[9-i];
    end
    rx_q.push_back(w);
    tick(1'b0, "miso_wait");
    tick(1'b0, "miso_wait");
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick(1'b1, "miso_a5_b7");
    tx_valid = 1'b0;
    tick(1'b0, "miso_a5_b6");
    tick(1'b1, "miso_a5_b5");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_miso", 32'(MISO), 32'(0));
    chk("async_rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("async_rst_rx_data", 32'(rx_data), 32'(0));
    SS_n = 1'b1; MOSI = 1'b0;
    tick(1'b0, "in_rst");
    rst = 1'b0;
    last_word = '0;
    tick(1'b0, "post_rst");
    run_frame(mk(1'b1, 10'h3C0, 10, 13, 8'hFF, 1'b1, 1'b0, 8'h00)); // READ_ADD after reset
    run_frame(mk(1'b1, 10'h3C0, 10, 13, 8'hA5, 1'b1, 1'b1, 8'hA5)); // then READ_DATA

    chk("rx_leftover", 32'(rx_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
SPI-slave front end and command sequencer for the 256x8 single-port RAM. It deserialises MOSI frames into the 10-bit command word {cmd[1:0], payload[7:0]} and pulses rx_valid toward the RAM. It tracks whether a read address has been loaded. On read-data commands it captures the RAM's tx_data/tx_valid response and serialises it back on MISO. The SPI bit clock is the system clk, sampled while SS_n is low.

Parameters:
DATA_W, 8, RAM data width and MISO bits per read response
TX_WAIT_MAX, 4, cycles to wait for tx_valid after a read-data rx_valid before abandoning the response

Ports:
clk  input  1  system/SPI clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
SS_n  input  1  SPI slave select, active low; frame boundary
MOSI  input  1  serial command/data in, MSB first
rx_data  output  10  assembled command word to RAM din
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  DATA_W  RAM read data
tx_valid  input  1  RAM read data valid
MISO  output  1  serial read data out, MSB first

Behaviour:
- Reset values: state=IDLE, MISO=0, rx_data=0, rx_valid=0, rd_addr_done=0, bit counter=0, tx shift register=0.
- IDLE: MISO=0. SS_n=0 at a clock edge moves the FSM to CHK_CMD.
- CHK_CMD: the sampled MOSI bit is a select bit only and is not stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 with rd_addr_done=0 -> READ_ADD.
  - MOSI=1 with rd_addr_done=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: the next 10 MOSI samples shift into the shift register MSB first (bit 9 first).
- On the 10th sample, rx_data is loaded and rx_valid is high for exactly the following cycle. rx_valid is never asserted for a frame with fewer than 10 bits.
- WRITE, READ_ADD: after rx_valid, the FSM holds until SS_n=1 and then returns to IDLE. Further MOSI bits in the same frame are ignored. A completed READ_ADD frame sets rd_addr_done=1.
- READ_DATA response sequence:
  - After rx_valid, the block waits for tx_valid. The RAM returns it 1 cycle later; the wait is bounded by TX_WAIT_MAX cycles.
  - On tx_valid, tx_data is latched.
  - Starting the next cycle, MISO drives bits DATA_W-1..0, one per cycle.
  - After the last bit: rd_addr_done clears, MISO returns to 0, and the FSM holds until SS_n=1.
  - On timeout: MISO stays 0 and rd_addr_done stays 1.
- tx_valid outside the READ_DATA wait window is ignored.
- SS_n=1 in any state returns the FSM to IDLE on the next edge, aborting the frame: no rx_valid, MISO=0, and rd_addr_done is unchanged.
- Reset mid-frame: all registers return to reset values immediately (asynchronous reset).
- The command bits inside rx_data are passed through unchecked; consistency between select bit and cmd[1:0] is the master's responsibility.
- Back-to-back frames need at least one cycle with SS_n=1 between them.

Test Plan:
1. Write address: SS_n low, MOSI 0 then 00_0010_1010 -> rx_data=0x02A, one rx_valid pulse, MISO=0 throughout; SS_n high -> IDLE.
2. Write data then read back:
   - Frame MOSI 0, 01_1100_0101 -> rx_data=0x1C5.
   - Frame MOSI 1, 10_0010_1010 -> rx_data=0x22A, rd_addr_done=1.
   - Frame MOSI 1, 11_xxxx_xxxx; tb RAM returns tx_data=0xC5 with tx_valid 1 cycle after rx_valid -> MISO shifts 1,1,0,0,0,1,0,1; then rd_addr_done=0.
3. Read-data timeout: READ_DATA frame with tx_valid held low -> after TX_WAIT_MAX=4 cycles MISO stays 0, rd_addr_done remains 1, and the next select-1 frame again enters READ_DATA.
4. Abort: SS_n raised after 6 data bits of a write frame -> no rx_valid, FSM returns to IDLE, rx_data keeps its previous value.
5. Async reset: assert rst mid-MISO shifting of 0xA5 -> MISO=0, rx_valid=0, rd_addr_done=0 immediately, without waiting for a clock edge; after release the next select-1 frame enters READ_ADD.
6. Read order: two consecutive select-1 frames with no intervening reset -> first routed to READ_ADD, second to READ_DATA; a third select-1 frame enters READ_ADD again.
